data_sram_arbiter: RTL and testbench

//  Shares the single-port data SRAM between the CPU load/store path and an auxiliary master (debug/DMA).

---
 rtl/data_sram_arbiter_pkg.sv | 16 +
 rtl/data_sram_arbiter_starve_ctr.sv | 32 +++
 rtl/data_sram_arbiter.sv | 93 +++++++++
 tb/tb_data_sram_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_arbiter_pkg.sv
// Shared types and helpers for the data SRAM arbiter: owner encoding and request bus layout.
package data_sram_arbiter_pkg;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_AUX = 1'b1
   } owner_e;

   localparam int STARVE_CW = 4;

   // Packed request bus is {req, wr, wstrb, addr, wdata}.
   function automatic int reqBusWidth(input int aw, input int dw);
      return 1 + 1 + dw / 8 + aw + dw;
   endfunction

endpackage

// File: rtl/data_sram_arbiter_starve_ctr.sv
// Aging counter for the auxiliary master: counts consecutive refused cycles and
// raises force_aux once AUX has waited STARVE_LIMIT cycles in a row.
module dsram_starve_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic aux_req,
   input  logic aux_grant,
   output logic force_aux
);
   import data_sram_arbiter_pkg::*;

   localparam logic [STARVE_CW-1:0] LIMIT = STARVE_CW'(STARVE_LIMIT);
   localparam logic [STARVE_CW-1:0] ONE   = STARVE_CW'(1);

   logic [STARVE_CW-1:0] r_starveCnt;

   // A grant or a withdrawn request ends the starvation run; otherwise saturate at the limit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_starveCnt <= '0;
      end else if (!aux_req || aux_grant) begin
         r_starveCnt <= '0;
      end else if (r_starveCnt != LIMIT) begin
         r_starveCnt <= r_starveCnt + ONE;
      end
   end

   assign force_aux = aux_req && (r_starveCnt == LIMIT);

endmodule

// File: rtl/data_sram_arbiter.sv
// Single-port data SRAM arbiter between the CPU load/store path and an auxiliary master,
// with CPU priority, AUX aging and a one-deep response tracker routing completions back.
module data_sram_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int AW           = 32,
   parameter int DW           = 32
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            cpu_req,
   input  logic            cpu_wr,
   input  logic [DW/8-1:0] cpu_wstrb,
   input  logic [AW-1:0]   cpu_addr,
   input  logic [DW-1:0]   cpu_wdata,
   output logic            cpu_addr_ok,
   output logic            cpu_data_ok,
   output logic [DW-1:0]   cpu_rdata,
   input  logic            aux_req,
   input  logic            aux_wr,
   input  logic [DW/8-1:0] aux_wstrb,
   input  logic [AW-1:0]   aux_addr,
   input  logic [DW-1:0]   aux_wdata,
   output logic            aux_addr_ok,
   output logic            aux_data_ok,
   output logic [DW-1:0]   aux_rdata,
   output logic            data_sram_en,
   output logic [DW/8-1:0] data_sram_wen,
   output logic [AW-1:0]   data_sram_addr,
   output logic [DW-1:0]   data_sram_wdata,
   input  logic [DW-1:0]   data_sram_rdata
);
   import data_sram_arbiter_pkg::*;

   localparam int SW     = DW / 8;
   localparam int REQ_WD = reqBusWidth(AW, DW);

   logic [REQ_WD-1:0] w_cpuBus, w_auxBus, w_winBus;
   logic              w_forceAux, w_auxGrant, w_cpuGrant;
   logic              w_winReq, w_winWr;
   logic [SW-1:0]     w_winStrb;
   logic [AW-1:0]     w_winAddr;
   logic [DW-1:0]     w_winData;

   logic   r_rspV;
   owner_e r_rspOwner;
   logic   r_rspWr;

   dsram_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starveCtr (
      .clk      (clk),
      .resetn   (resetn),
      .aux_req  (aux_req),
      .aux_grant(w_auxGrant),
      .force_aux(w_forceAux)
   );

   assign w_cpuBus = {cpu_req, cpu_wr, cpu_wstrb, cpu_addr, cpu_wdata};
   assign w_auxBus = {aux_req, aux_wr, aux_wstrb, aux_addr, aux_wdata};

   // AUX takes the port when CPU is idle or when aging says it has waited long enough.
   assign w_auxGrant = resetn && aux_req && (!cpu_req || w_forceAux);
   assign w_cpuGrant = resetn && cpu_req && !w_auxGrant;

   assign w_winBus = w_auxGrant ? w_auxBus : w_cpuBus;
   assign {w_winReq, w_winWr, w_winStrb, w_winAddr, w_winData} = w_winBus;

   assign cpu_addr_ok     = w_cpuGrant;
   assign aux_addr_ok     = w_auxGrant;
   assign data_sram_en    = resetn && w_winReq;
   assign data_sram_wen   = (data_sram_en && w_winWr) ? w_winStrb : '0;
   assign data_sram_addr  = data_sram_en ? w_winAddr : '0;
   assign data_sram_wdata = data_sram_en ? w_winData : '0;

   // Remember who issued this cycle's access so next cycle's SRAM data goes back to them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rspV     <= 1'b0;
         r_rspOwner <= OWNER_CPU;
         r_rspWr    <= 1'b0;
      end else begin
         r_rspV     <= data_sram_en;
         r_rspOwner <= w_auxGrant ? OWNER_AUX : OWNER_CPU;
         r_rspWr    <= w_winWr;
      end
   end

   assign cpu_data_ok = r_rspV && (r_rspOwner == OWNER_CPU);
   assign aux_data_ok = r_rspV && (r_rspOwner == OWNER_AUX);
   assign cpu_rdata   = (cpu_data_ok && !r_rspWr) ? data_sram_rdata : '0;
   assign aux_rdata   = (aux_data_ok && !r_rspWr) ? data_sram_rdata : '0;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Self-checking bench for data_sram_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model with its own copy of SRAM contents.
module tb_data_sram_arbiter;

   localparam int LIMIT = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int SW    = DW / 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cpu_req = 1'b0, cpu_wr = 1'b0;
   logic [SW-1:0] cpu_wstrb = '0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_addr_ok, cpu_data_ok;
   logic [DW-1:0] cpu_rdata;
   logic          aux_req = 1'b0, aux_wr = 1'b0;
   logic [SW-1:0] aux_wstrb = '0;
   logic [AW-1:0] aux_addr = '0;
   logic [DW-1:0] aux_wdata = '0;
   logic          aux_addr_ok, aux_data_ok;
   logic [DW-1:0] aux_rdata;
   logic          data_sram_en;
   logic [SW-1:0] data_sram_wen;
   logic [AW-1:0] data_sram_addr;
   logic [DW-1:0] data_sram_wdata;
   logic [DW-1:0] data_sram_rdata = '0;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          refused = 0;
   bit          pendV = 0, pendAux = 0, pendWr = 0;
   logic [31:0] pendData = '0;
   logic [31:0] refMem  [0:1023];
   logic [31:0] sramMem [0:1023];
   bit          expCpuWin, expAuxWin;

   // Observed values from the most recent cycle
   logic          obsCpuOk, obsAuxOk, obsCpuDok, obsAuxDok;
   logic [31:0]   obsCpuRdata, obsAuxRdata;
   logic [SW-1:0] obsWen;

   data_sram_arbiter #(.STARVE_LIMIT(LIMIT), .AW(AW), .DW(DW)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wstrb(cpu_wstrb), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok),
      .cpu_rdata(cpu_rdata),
      .aux_req(aux_req), .aux_wr(aux_wr), .aux_wstrb(aux_wstrb), .aux_addr(aux_addr),
      .aux_wdata(aux_wdata), .aux_addr_ok(aux_addr_ok), .aux_data_ok(aux_data_ok),
      .aux_rdata(aux_rdata),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM attached to the DUT pins, read data one cycle after enable
   always @(posedge clk) begin
      if (data_sram_en) begin
         for (int b = 0; b < SW; b++)
            if (data_sram_wen[b]) sramMem[data_sram_addr[11:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
         data_sram_rdata <= sramMem[data_sram_addr[11:2]];
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit isAux, input bit req, input bit wr, input logic [3:0] strb,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (isAux) begin
         aux_req = req; aux_wr = wr; aux_wstrb = strb; aux_addr = addr; aux_wdata = wdata;
      end else begin
         cpu_req = req; cpu_wr = wr; cpu_wstrb = strb; cpu_addr = addr; cpu_wdata = wdata;
      end
   endtask

   // One clock cycle: predict, compare, advance the model, then move to posedge+2.
   task automatic stepCycle();
      bit          eAux, eCpu, eEn, eWr;
      logic [3:0]  eWen;
      logic [31:0] eAddr, eData;
      int          idx;
      #1;
      eAux  = aux_req && (!cpu_req || refused == LIMIT);
      eCpu  = cpu_req && !eAux;
      eEn   = eAux || eCpu;
      eWr   = eAux ? aux_wr : (eCpu ? cpu_wr : 1'b0);
      eAddr = eAux ? aux_addr : (eCpu ? cpu_addr : 32'h0);
      eData = eAux ? aux_wdata : (eCpu ? cpu_wdata : 32'h0);
      eWen  = eWr ? (eAux ? aux_wstrb : cpu_wstrb) : 4'h0;

      checkOutput("cpuAddrOk", cpu_addr_ok, eCpu);
      checkOutput("auxAddrOk", aux_addr_ok, eAux);
      checkOutput("sramEn", data_sram_en, eEn);
      checkOutput("sramWen", data_sram_wen, eWen);
      checkOutput("sramAddr", data_sram_addr, eAddr);
      checkOutput("sramWdata", data_sram_wdata, eData);
      checkOutput("cpuDataOk", cpu_data_ok, pendV && !pendAux);
      checkOutput("auxDataOk", aux_data_ok, pendV && pendAux);
      checkOutput("cpuRdata", cpu_rdata, (pendV && !pendAux && !pendWr) ? pendData : 32'h0);
      checkOutput("auxRdata", aux_rdata, (pendV && pendAux && !pendWr) ? pendData : 32'h0);

      obsCpuOk = cpu_addr_ok; obsAuxOk = aux_addr_ok;
      obsCpuDok = cpu_data_ok; obsAuxDok = aux_data_ok;
      obsCpuRdata = cpu_rdata; obsAuxRdata = aux_rdata; obsWen = data_sram_wen;

      if (aux_req && !eAux) refused = (refused < LIMIT) ? refused + 1 : LIMIT;
      else refused = 0;
      pendV = eEn; pendAux = eAux; pendWr = eWr;
      if (eEn) begin
         idx = int'(eAddr[11:2]);
         pendData = refMem[idx];
         for (int b = 0; b < SW; b++)
            if (eWen[b]) refMem[idx][8*b +: 8] = eData[8*b +: 8];
      end
      expCpuWin = eCpu; expAuxWin = eAux;
      @(posedge clk);
      #2;
   endtask

   task automatic randLoad(input bit isAux);
      applyStimulus(isAux, 1'b1, 1'b0, 4'($urandom_range(1, 15)), {20'h0, 10'($urandom_range(0, 31)), 2'b00}, $urandom);
   endtask

   initial begin
      logic [8:0] pattern9;
      logic [4:0] pattern5;
      bit         cpuHold, auxHold;

      for (int i = 0; i < 1024; i++) begin
         refMem[i]  = 32'hA5A50000 | 32'(i);
         sramMem[i] = 32'hA5A50000 | 32'(i);
      end
      refMem[64]  = 32'hDEADBEEF;
      sramMem[64] = 32'hDEADBEEF;

      // Reset held with both masters requesting: nothing may be granted
      randLoad(1'b0);
      randLoad(1'b1);
      repeat (2) @(negedge clk);
      checkOutput("rstCpuAddrOk", cpu_addr_ok, 1'b0);
      checkOutput("rstAuxAddrOk", aux_addr_ok, 1'b0);
      checkOutput("rstSramEn", data_sram_en, 1'b0);
      checkOutput("rstCpuDataOk", cpu_data_ok, 1'b0);
      checkOutput("rstAuxDataOk", aux_data_ok, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(posedge clk);
      #2;
      resetn = 1'b1;

      // CPU-only load from 0x100
      applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("deadbeefData", obsCpuRdata, 32'hDEADBEEF);
      checkOutput("deadbeefDataOk", obsCpuDok, 1'b1);
      checkOutput("deadbeefAuxOk", obsAuxDok, 1'b0);

      // Both masters request every cycle: four CPU grants, then one AUX, then CPU again
      randLoad(1'b0);
      randLoad(1'b1);
      for (int i = 0; i < 9; i++) begin
         stepCycle();
         pattern9[i] = obsAuxOk;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("starvePattern", pattern9, 9'b000010000);

      // Back-to-back store then load to the same word
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'h1234);
      stepCycle();
      checkOutput("storeWen", obsWen, 4'b0011);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'b1111, 32'h10, 32'h0);
      stepCycle();
      checkOutput("loadWen", obsWen, 4'b0000);
      checkOutput("storeDataOk", obsCpuDok, 1'b1);
      checkOutput("storeRdata", obsCpuRdata, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("loadDataOk", obsCpuDok, 1'b1);
      checkOutput("loadRdata", obsCpuRdata, 32'hA5A51234);

      // AUX load followed by CPU store: completion and new accept overlap
      randLoad(1'b1);
      stepCycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'b1100, 32'h20, 32'hCAFE0000);
      stepCycle();
      checkOutput("overlapAuxDataOk", obsAuxDok, 1'b1);
      checkOutput("overlapCpuAddrOk", obsCpuOk, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("overlapCpuDataOk", obsCpuDok, 1'b1);
      checkOutput("overlapAuxQuiet", obsAuxDok, 1'b0);

      // Reset right after an acceptance, with AUX partly aged
      randLoad(1'b0);
      randLoad(1'b1);
      stepCycle();
      stepCycle();
      resetn = 1'b0;
      #1;
      checkOutput("dropCpuDataOk", cpu_data_ok, 1'b0);
      checkOutput("dropAuxDataOk", aux_data_ok, 1'b0);
      checkOutput("dropSramEn", data_sram_en, 1'b0);
      checkOutput("dropCpuAddrOk", cpu_addr_ok, 1'b0);
      pendV = 0;
      refused = 0;
      @(posedge clk);
      #2;
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         stepCycle();
         pattern5[i] = obsAuxOk;
      end
      checkOutput("postResetStarve", pattern5, 5'b10000);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      stepCycle();

      // Idle stretch
      for (int i = 0; i < 10; i++) begin
         stepCycle();
         checkOutput("idleWen", obsWen, 4'h0);
      end

      // Randomized traffic; each master holds its request until accepted
      cpuHold = 0;
      auxHold = 0;
      for (int i = 0; i < 400; i++) begin
         if (!cpuHold) begin
            if ($urandom_range(0, 99) < 65) begin
               applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                             {20'h0, 10'($urandom_range(0, 31)), 2'b00}, $urandom);
               cpuHold = 1;
            end else applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         end
         if (!auxHold) begin
            if ($urandom_range(0, 99) < 50) begin
               applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                             {20'h0, 10'($urandom_range(0, 31)), 2'b00}, $urandom);
               auxHold = 1;
            end else applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         end
         stepCycle();
         if (expCpuWin) cpuHold = 0;
         if (expAuxWin) auxHold = 0;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      stepCycle();
      stepCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
